// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - ID-stage operand hazard scoreboard with forwarding select
// Optional stall statistics outputs enabled by defining ID_SB_STAT_EN.
module id_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NFWD  = 2,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 ex_allowin,
    input  logic                 rs1_en,
    input  logic [AW-1:0]        rs1_addr,
    input  logic                 rs2_en,
    input  logic [AW-1:0]        rs2_addr,
    input  logic [DW-1:0]        rf_rdata1,
    input  logic [DW-1:0]        rf_rdata2,
    input  logic                 issue_we,
    input  logic [AW-1:0]        issue_dest,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*DW-1:0]   fwd_data,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [DW-1:0]        wb_data,
    input  logic                 kill_valid,
    input  logic [AW-1:0]        kill_addr,
    output logic [DW-1:0]        rs1_value,
    output logic [DW-1:0]        rs2_value,
    output logic                 id_readygo,
    output logic                 id_fire,
    output logic                 sb_busy
`ifdef ID_SB_STAT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          stall_load
`endif
);

    logic [CNT_W-1:0] r_pending [NREG];
    logic [CNT_W-1:0] w_next    [NREG];
    logic [NREG-1:0]  w_underflow;

    logic [AW-1:0] w_src_addr [2];
    logic [1:0]    w_src_en;
    logic [DW-1:0] w_src_rf   [2];
    logic [DW-1:0] w_src_val  [2];
    logic [1:0]    w_haz;
    logic [1:0]    w_load_haz;
    logic          w_full;

    assign w_src_addr[0] = rs1_addr;
    assign w_src_addr[1] = rs2_addr;
    assign w_src_en      = {rs2_en, rs1_en};
    assign w_src_rf[0]   = rf_rdata1;
    assign w_src_rf[1]   = rf_rdata2;

    // Priority: youngest forward channel, then writeback, then untracked pending, then RF.
    always_comb begin : operand_select
        logic found;
        for (int s = 0; s < 2; s++) begin
            w_src_val[s]  = '0;
            w_haz[s]      = 1'b0;
            w_load_haz[s] = 1'b0;
            found         = 1'b0;
            if (w_src_en[s] && w_src_addr[s] != '0) begin
                for (int k = 0; k < NFWD; k++) begin
                    if (!found && fwd_valid[k] && fwd_addr[k*AW +: AW] == w_src_addr[s]) begin
                        found = 1'b1;
                        if (fwd_ready[k]) begin
                            w_src_val[s] = fwd_data[k*DW +: DW];
                        end else begin
                            w_haz[s]      = 1'b1;
                            w_load_haz[s] = 1'b1;
                        end
                    end
                end
                if (!found) begin
                    if (wb_valid && wb_addr == w_src_addr[s])
                        w_src_val[s] = wb_data;
                    else if (r_pending[w_src_addr[s]] != '0)
                        w_haz[s] = 1'b1;
                    else
                        w_src_val[s] = w_src_rf[s];
                end
            end
        end
    end

    assign rs1_value  = w_src_val[0];
    assign rs2_value  = w_src_val[1];
    assign w_full     = issue_we && issue_dest != '0 && r_pending[issue_dest] == {CNT_W{1'b1}};
    assign id_readygo = !w_haz[0] && !w_haz[1] && !w_full;
    assign id_fire    = id_valid && id_readygo && ex_allowin;

    // Net of one increment and up to two decrements; underflow clamps at zero.
    always_comb begin : counter_next
        int sum;
        for (int i = 0; i < NREG; i++) begin
            sum = int'(r_pending[i]);
            if (i != 0) begin
                if (id_fire && issue_we && int'(issue_dest) == i) sum = sum + 1;
                if (wb_valid && int'(wb_addr) == i)               sum = sum - 1;
                if (kill_valid && int'(kill_addr) == i)           sum = sum - 1;
            end
            w_underflow[i] = (sum < 0);
            w_next[i]      = (i == 0 || sum < 0) ? '0 : CNT_W'(sum);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) r_pending[i] <= '0;
            else     r_pending[i] <= w_next[i];
        end
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (r_pending[i] != '0) sb_busy = 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_underflow != '0)
            $error("id_scoreboard: pending counter decremented at zero (mask %h)", w_underflow);
    end
`endif

`ifdef ID_SB_STAT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_stall_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_stall_load   <= '0;
        end else if (id_valid && !id_readygo) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_load_haz != '0) r_stall_load <= r_stall_load + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign stall_load   = r_stall_load;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed self-checking bench for id_scoreboard
module tb_id_scoreboard;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NFWD = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, ex_allowin;
    logic             rs1_en, rs2_en;
    logic [AW-1:0]    rs1_addr, rs2_addr;
    logic [DW-1:0]    rf_rdata1, rf_rdata2;
    logic             issue_we;
    logic [AW-1:0]    issue_dest;
    logic [NFWD-1:0]  fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0] fwd_addr;
    logic [NFWD*DW-1:0] fwd_data;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             kill_valid;
    logic [AW-1:0]    kill_addr;
    logic [DW-1:0]    rs1_value, rs2_value;
    logic             id_readygo, id_fire, sb_busy;

    int total = 0;
    int bad = 0;

    id_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .ex_allowin(ex_allowin),
        .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs2_en(rs2_en), .rs2_addr(rs2_addr),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .issue_we(issue_we), .issue_dest(issue_dest),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .kill_valid(kill_valid), .kill_addr(kill_addr),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .id_readygo(id_readygo), .id_fire(id_fire), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; ex_allowin = 0; rs1_en = 0; rs2_en = 0;
        rs1_addr = 0; rs2_addr = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        issue_we = 0; issue_dest = 0; fwd_valid = 0; fwd_ready = 0;
        fwd_addr = 0; fwd_data = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
        kill_valid = 0; kill_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); rst = 0; #1;
        total++; if (sb_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sb_busy); end
        id_valid = 1; rs1_en = 1; rs1_addr = 5; rf_rdata1 = 32'h11;
        rs2_en = 1; rs2_addr = 6; rf_rdata2 = 32'h22; #1;
        total++; if (rs1_value !== 32'h11) begin bad++; $display("FAIL rf_rs1 got=%h exp=11", rs1_value); end
        total++; if (rs2_value !== 32'h22) begin bad++; $display("FAIL rf_rs2 got=%h exp=22", rs2_value); end
        total++; if (id_readygo !== 1'b1) begin bad++; $display("FAIL rf_readygo got=%b exp=1", id_readygo); end
    endtask

    task automatic test_fwd_priority();
        idle(); id_valid = 1; rs1_en = 1; rs1_addr = 5; rf_rdata1 = 32'h11;
        fwd_valid = 2'b11; fwd_ready = 2'b11; fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'hBB, 32'hAA}; #1;
        total++; if (rs1_value !== 32'hAA) begin bad++; $display("FAIL fwd_ch0_prio got=%h exp=aa", rs1_value); end
        fwd_valid = 2'b10; #1;
        total++; if (rs1_value !== 32'hBB) begin bad++; $display("FAIL fwd_ch1 got=%h exp=bb", rs1_value); end
        fwd_valid = 2'b00; wb_valid = 1; wb_addr = 5; wb_data = 32'hCC; #1;
        total++; if (rs1_value !== 32'hCC) begin bad++; $display("FAIL wb_bypass got=%h exp=cc", rs1_value); end
        fwd_valid = 2'b01; fwd_addr = {5'd5, 5'd8}; #1;
        total++; if (rs1_value !== 32'hCC) begin bad++; $display("FAIL fwd_addr_miss got=%h exp=cc", rs1_value); end
    endtask

    task automatic test_load_stall();
        idle(); id_valid = 1; ex_allowin = 1; rs2_en = 1; rs2_addr = 7;
        fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_addr = {5'd0, 5'd7}; #1;
        for (int c = 0; c < 2; c++) begin
            total++; if (id_readygo !== 1'b0 || id_fire !== 1'b0) begin bad++;
                $display("FAIL load_stall cyc=%0d readygo=%b fire=%b exp=0/0", c, id_readygo, id_fire); end
            tick();
        end
        fwd_ready = 2'b01; fwd_data = {32'h0, 32'h1234}; #1;
        total++; if (rs2_value !== 32'h1234) begin bad++; $display("FAIL load_data got=%h exp=1234", rs2_value); end
        total++; if (id_fire !== 1'b1) begin bad++; $display("FAIL load_fire got=%b exp=1", id_fire); end
        tick();
    endtask

    task automatic test_counter_full();
        idle(); id_valid = 1; ex_allowin = 1; issue_we = 1; issue_dest = 9;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (id_fire !== 1'b1) begin bad++; $display("FAIL fill_fire n=%0d got=%b exp=1", c, id_fire); end
            tick();
        end
        total++; if (id_readygo !== 1'b0) begin bad++; $display("FAIL full_block got=%b exp=0", id_readygo); end
        total++; if (sb_busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", sb_busy); end
        issue_we = 0; rs1_en = 1; rs1_addr = 9; #1;
        total++; if (id_readygo !== 1'b0) begin bad++; $display("FAIL untracked_haz got=%b exp=0", id_readygo); end
        idle(); wb_valid = 1; wb_addr = 9; tick();
        idle(); id_valid = 1; issue_we = 1; issue_dest = 9; #1;
        total++; if (id_readygo !== 1'b1) begin bad++; $display("FAIL after_wb_ready got=%b exp=1", id_readygo); end
        idle(); wb_valid = 1; wb_addr = 9; tick(); tick(); idle(); #1;
        total++; if (sb_busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", sb_busy); end
    endtask

    task automatic test_inc_dec_same();
        idle(); id_valid = 1; ex_allowin = 1; issue_we = 1; issue_dest = 3; tick();
        wb_valid = 1; wb_addr = 3; #1;
        total++; if (id_fire !== 1'b1) begin bad++; $display("FAIL incdec_fire got=%b exp=1", id_fire); end
        tick();
        idle(); id_valid = 1; rs1_en = 1; rs1_addr = 3; #1;
        total++; if (id_readygo !== 1'b0) begin bad++; $display("FAIL incdec_pending got=%b exp=0", id_readygo); end
        idle(); kill_valid = 1; kill_addr = 3; tick();
        idle(); id_valid = 1; rs1_en = 1; rs1_addr = 3; rf_rdata1 = 32'h33; #1;
        total++; if (sb_busy !== 1'b0) begin bad++; $display("FAIL kill_busy got=%b exp=0", sb_busy); end
        total++; if (id_readygo !== 1'b1 || rs1_value !== 32'h33) begin bad++;
            $display("FAIL kill_read readygo=%b val=%h exp=1/33", id_readygo, rs1_value); end
    endtask

    task automatic test_r0_and_reset();
        idle(); id_valid = 1; rs1_en = 1; rs1_addr = 0; rf_rdata1 = 32'h77;
        fwd_valid = 2'b01; fwd_ready = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFF}; #1;
        total++; if (rs1_value !== 32'h0 || id_readygo !== 1'b1) begin bad++;
            $display("FAIL r0_zero val=%h readygo=%b exp=0/1", rs1_value, id_readygo); end
        fwd_ready = 2'b00; #1;
        total++; if (id_readygo !== 1'b1) begin bad++; $display("FAIL r0_no_stall got=%b exp=1", id_readygo); end
        idle(); id_valid = 1; ex_allowin = 1; issue_we = 1; issue_dest = 0; tick(); idle(); #1;
        total++; if (sb_busy !== 1'b0) begin bad++; $display("FAIL r0_untracked got=%b exp=0", sb_busy); end
        id_valid = 1; ex_allowin = 1; issue_we = 1; issue_dest = 4; tick();
        issue_dest = 6; tick(); idle(); #1;
        total++; if (sb_busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy got=%b exp=1", sb_busy); end
        rst = 1; tick(); rst = 0; #1;
        total++; if (sb_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", sb_busy); end
        id_valid = 1; rs1_en = 1; rs1_addr = 4; rs2_en = 1; rs2_addr = 6; #1;
        total++; if (id_readygo !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", id_readygo); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_fwd_priority();
        test_load_stall();
        test_counter_full();
        test_inc_dec_same();
        test_r0_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
